mcu_mem_bus: RTL

Memory and memory-mapped I/O slave directly downstream of the microcontroller. It consumes the core's `addr`, `dout` and `rw`, and returns read data on the core's `din`. It contains a word-addressed synchronous RAM, a GPIO output/input register pair, and a down-counting timer with an expiry flag.

---
 rtl/mcu_bus_pkg.sv | 19 +
 rtl/mcu_timer.sv | 118 +++++++++++
 rtl/mcu_mem_bus.sv | 109 ++++++++++
 3 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared constants and types for the microcontroller memory / memory-mapped I/O slave.
package mcu_bus_pkg;

   localparam logic [15:0] ADDR_GPIO_OUT = 16'hFF00;
   localparam logic [15:0] ADDR_GPIO_IN  = 16'hFF01;
   localparam logic [15:0] ADDR_TCTRL    = 16'hFF02;
   localparam logic [15:0] ADDR_TLOAD    = 16'hFF03;
   localparam logic [15:0] ADDR_TCOUNT   = 16'hFF04;
   localparam logic [15:0] ADDR_TSTAT    = 16'hFF05;

   localparam int TCTRL_EN     = 0;
   localparam int TCTRL_RELOAD = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

endpackage

// File: rtl/mcu_timer.sv
// Down-counting timer with one-shot or auto-reload mode and a sticky expiry flag.
module mcu_timer
   import mcu_bus_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ctrl_we,
   input  logic         load_we,
   input  logic         stat_we,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] count,
   output logic [1:0]   ctrl,
   output logic [N-1:0] load,
   output logic         flag
);

   localparam logic [N-1:0] ZERO_C = {N{1'b0}};
   localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};

   timer_state_t state_r, state_s;
   logic [N-1:0] count_r, count_s;
   logic [N-1:0] load_r, load_s;
   logic [1:0]   ctrl_r, ctrl_s;
   logic         flag_r, flag_s;

   // Next-state logic: countdown and expiry first, then a TCTRL write overrides EN/RELOAD.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      ctrl_s  = ctrl_r;
      load_s  = load_r;
      flag_s  = flag_r;

      if (load_we) begin
         load_s = wdata;
      end else begin
         load_s = load_r;
      end

      if (stat_we && wdata[0]) begin
         flag_s = 1'b0;
      end else begin
         flag_s = flag_r;
      end

      case (state_r)
         IDLE: begin
            if (ctrl_we) begin
               ctrl_s = wdata[1:0];
               if (wdata[TCTRL_EN]) begin
                  state_s = RUN;
                  count_s = load_r;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (count_r != ZERO_C) begin
               count_s = count_r - ONE_C;
            end else begin
               // Expiry beats a same-edge TSTAT clear.
               flag_s = 1'b1;
               if (ctrl_r[TCTRL_RELOAD]) begin
                  count_s = load_r;
               end else begin
                  ctrl_s[TCTRL_EN] = 1'b0;
                  state_s          = IDLE;
               end
            end
            if (ctrl_we) begin
               ctrl_s = wdata[1:0];
               if (!wdata[TCTRL_EN]) begin
                  state_s = IDLE;
                  count_s = count_r;
               end else if (count_r == ZERO_C) begin
                  state_s = RUN;
                  count_s = wdata[TCTRL_RELOAD] ? load_r : ZERO_C;
               end else begin
                  state_s = RUN;
               end
            end else begin
               ctrl_s = ctrl_s;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Timer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         count_r <= ZERO_C;
         load_r  <= ZERO_C;
         ctrl_r  <= 2'b00;
         flag_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         load_r  <= load_s;
         ctrl_r  <= ctrl_s;
         flag_r  <= flag_s;
      end
   end

   assign count = count_r;
   assign ctrl  = ctrl_r;
   assign load  = load_r;
   assign flag  = flag_r;

endmodule

// File: rtl/mcu_mem_bus.sv
// Memory / MMIO slave: RAM, GPIO with input synchronizer, optional timer.
// Define MCU_MEM_BUS_TIMER_EN to build the timer; otherwise its registers decode as unmapped.
module mcu_mem_bus
   import mcu_bus_pkg::*;
#(
   parameter int    N         = 16,
   parameter int    A         = 8,
   parameter string INIT_FILE = ""
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rw,
   input  logic [N-1:0] addr,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] rdata,
   input  logic [N-1:0] gpio_in,
   output logic [N-1:0] gpio_out,
   output logic         timer_flag
);

   localparam logic [N-1:0] ZERO_C = {N{1'b0}};

   logic [N-1:0] mem_r [0:(2**A)-1];
   logic [N-1:0] rdata_r;
   logic [N-1:0] gpio_out_r;
   logic [N-1:0] sync1_r;
   logic [N-1:0] sync2_r;
   logic [N-1:0] rd_mux_s;
   logic         ram_sel_s;
   logic         wr_s;

   // Only the low 2^A words are RAM; everything above up to the I/O page is unmapped.
   assign ram_sel_s = (addr[N-1:A] == {(N-A){1'b0}});
   assign wr_s      = !rw;

`ifdef MCU_MEM_BUS_TIMER_EN
   logic [N-1:0] t_count_s;
   logic [N-1:0] t_load_s;
   logic [1:0]   t_ctrl_s;
   logic         t_flag_s;

   mcu_timer #(.N(N)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .ctrl_we (wr_s && (addr == ADDR_TCTRL)),
      .load_we (wr_s && (addr == ADDR_TLOAD)),
      .stat_we (wr_s && (addr == ADDR_TSTAT)),
      .wdata   (wdata),
      .count   (t_count_s),
      .ctrl    (t_ctrl_s),
      .load    (t_load_s),
      .flag    (t_flag_s)
   );

   assign timer_flag = t_flag_s;
`else
   assign timer_flag = 1'b0;
`endif

   // RAM write port; reset blocks writes but never clears contents.
   always_ff @(posedge clk) begin
      if (!rst && wr_s && ram_sel_s) begin
         mem_r[addr[A-1:0]] <= wdata;
      end
   end

   // Read data selection for the decoded address.
   always_comb begin
      rd_mux_s = ZERO_C;
      if (ram_sel_s) begin
         rd_mux_s = mem_r[addr[A-1:0]];
      end else begin
         case (addr)
            ADDR_GPIO_OUT: rd_mux_s = gpio_out_r;
            ADDR_GPIO_IN:  rd_mux_s = sync2_r;
`ifdef MCU_MEM_BUS_TIMER_EN
            ADDR_TCTRL:    rd_mux_s = {{(N-2){1'b0}}, t_ctrl_s};
            ADDR_TLOAD:    rd_mux_s = t_load_s;
            ADDR_TCOUNT:   rd_mux_s = t_count_s;
            ADDR_TSTAT:    rd_mux_s = {{(N-1){1'b0}}, t_flag_s};
`endif
            default:       rd_mux_s = ZERO_C;
         endcase
      end
   end

   // Read data register, GPIO output register and gpio_in synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r    <= ZERO_C;
         gpio_out_r <= ZERO_C;
         sync1_r    <= ZERO_C;
         sync2_r    <= ZERO_C;
      end else begin
         if (rw) begin
            rdata_r <= rd_mux_s;
         end
         if (wr_s && (addr == ADDR_GPIO_OUT)) begin
            gpio_out_r <= wdata;
         end
         sync1_r <= gpio_in;
         sync2_r <= sync1_r;
      end
   end

   assign rdata    = rdata_r;
   assign gpio_out = gpio_out_r;

endmodule
